// File: rtl/dst_ram.sv
// Write-random / read-serial result buffer: the pipeline writes words at any address,
// and a go request streams all DEPTH words out in address order over valid/ready.
module dst_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 784,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cenw,
    input  logic [AW-1:0] aw,
    input  logic [W-1:0]  dw,
    input  logic          go,
    input  logic          ordy,
    output logic          ovld,
    output logic [W-1:0]  data_o,
    output logic          olast,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  rd_q;
    logic [AW-1:0] ra_q, ra_d;
    logic          rv_q, rl_q;
    logic          ovld_q, ovld_d;
    logic [W-1:0]  dat_q, dat_d;
    logic          olast_q, olast_d;
    logic          sv_q, sv_d;
    logic [W-1:0]  sdat_q, sdat_d;
    logic          slast_q, slast_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          pop;
    logic          issue;
    logic          ra_end;
    logic          wr_ok;
    logic [1:0]    fill;

    assign ra_end = (ra_q == AW'(DEPTH - 1));
    assign pop    = ovld_q & ordy;
    assign wr_ok  = !cenw && ({1'b0, aw} < (AW + 1)'(DEPTH));

    // Words owed to the output stage once this edge's transfer leaves.
    assign fill = {1'b0, ovld_q} + {1'b0, sv_q} + {1'b0, rv_q} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[aw] <= dw;
        end
        if (issue) begin
            rd_q <= mem[ra_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go) state_d = RUN;
            RUN:     if (issue && ra_end) state_d = FLUSH;
            FLUSH:   if (pop && olast_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue  = (state_q == RUN) && (fill < 2'd2);
        ra_d   = ra_q;
        if (state_q == IDLE && go) begin
            ra_d = '0;
        end else if (issue && !ra_end) begin
            ra_d = ra_q + 1'b1;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_q == FLUSH) && (state_d == IDLE);
    end

    always_comb begin
        ovld_d  = ovld_q;
        dat_d   = dat_q;
        olast_d = olast_q;
        sv_d    = sv_q;
        sdat_d  = sdat_q;
        slast_d = slast_q;
        if (!ovld_q || pop) begin
            if (sv_q) begin
                ovld_d  = 1'b1;
                dat_d   = sdat_q;
                olast_d = slast_q;
                sv_d    = rv_q;
                sdat_d  = rv_q ? rd_q : sdat_q;
                slast_d = rv_q & rl_q;
            end else begin
                ovld_d  = rv_q;
                dat_d   = rv_q ? rd_q : dat_q;
                olast_d = rv_q & rl_q;
            end
        end else if (rv_q) begin
            sv_d    = 1'b1;
            sdat_d  = rd_q;
            slast_d = rl_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_q    <= '0;
            rv_q    <= 1'b0;
            rl_q    <= 1'b0;
            ovld_q  <= 1'b0;
            dat_q   <= '0;
            olast_q <= 1'b0;
            sv_q    <= 1'b0;
            sdat_q  <= '0;
            slast_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ra_q    <= ra_d;
            rv_q    <= issue;
            rl_q    <= issue && ra_end;
            ovld_q  <= ovld_d;
            dat_q   <= dat_d;
            olast_q <= olast_d;
            sv_q    <= sv_d;
            sdat_q  <= sdat_d;
            slast_q <= slast_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ovld   = ovld_q;
    assign data_o = dat_q;
    assign olast  = olast_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_dst_ram.sv
// Bench for dst_ram: random backpressure and writes against an array/counter
// model of the stream, plus literal checks on selected words.
module tb_dst_ram;

    localparam int D = 784;

    logic       clk = 1'b0;
    logic       rst;
    logic       cenw;
    logic [9:0] aw;
    logic [7:0] dw;
    logic       go;
    logic       ordy;
    logic       ovld;
    logic [7:0] data_o;
    logic       olast;
    logic       busy;
    logic       done;

    dst_ram #(.W(8), .DEPTH(D), .AW(10)) dut (
        .clk(clk), .rst(rst), .cenw(cenw), .aw(aw), .dw(dw),
        .go(go), .ordy(ordy), .ovld(ovld), .data_o(data_o),
        .olast(olast), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    logic [7:0] refmem [D];
    logic [7:0] expq [D];
    logic [7:0] got [D];
    int   cnt = 0;
    int   cnt0 = 0;
    int   cyc = 0;
    int   ndone = 0;
    bit   m_busy = 0;
    bit   m_done = 0;
    bit   busy_b;
    bit   p_ovld = 0;
    bit   p_ordy = 0;
    logic [7:0] p_dat;
    logic p_last;
    bit   rnd = 0;
    bit   stall = 0;

    // Model: a stream is a snapshot of memory at go, patched by writes that land
    // well ahead of the read front; words appear 3 edges after go, gap-free.
    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0;
            m_done = 0;
            p_ovld = 0;
        end else begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("ovld", 32'(ovld), 32'(m_busy && cyc >= 3));
            if (ovld && cnt < D) begin
                chk("data", 32'(data_o), 32'(expq[cnt]));
                chk("olast", 32'(olast), 32'(cnt == D - 1));
                got[cnt] = data_o;
            end
            if (p_ovld && !p_ordy) begin
                chk("hold", 32'({ovld, olast, data_o}), 32'({1'b1, p_last, p_dat}));
            end
            p_ovld = ovld;
            p_ordy = ordy;
            p_dat  = data_o;
            p_last = olast;
            busy_b = m_busy;
            cnt0   = cnt;
            m_done = 0;
            if (m_busy) cyc++;
            if (ovld && ordy && m_busy) begin
                cnt++;
                if (cnt == D) begin
                    m_busy = 0;
                    m_done = 1;
                    ndone++;
                end
            end
            if (!cenw && aw < 10'(D)) begin
                refmem[aw] = dw;
                if (busy_b && m_busy && int'(aw) >= cnt0 + 3) expq[aw] = dw;
            end
            if (go && !busy_b) begin
                m_busy = 1;
                cyc = 1;
                cnt = 0;
                expq = refmem;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        go   = 1'b0;
        cenw = 1'b1;
        ordy = stall ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    endtask

    task automatic run_stream(input int mode);
        int guard;
        int d0;
        int sc;
        bit f1;
        bit f2;
        d0 = ndone;
        guard = 0;
        sc = 0;
        f1 = 0;
        f2 = 0;
        rnd = (mode != 0);
        tick();
        go = 1'b1;
        while (ndone == d0 && guard < 5000) begin
            tick();
            guard++;
            if (mode == 1) begin
                if (!f1 && cnt >= 100) begin
                    go = 1'b1;
                    f1 = 1;
                end else if (f1 && !f2) begin
                    cenw = 1'b0;
                    aw = 10'd800;
                    dw = 8'hFF;
                    f2 = 1;
                end
            end
            if (mode == 2) begin
                if (!f1 && cnt >= 298) begin
                    stall = 1;
                    ordy = 1'b0;
                    f1 = 1;
                end else if (f1 && !f2) begin
                    sc++;
                    if (sc == 3) begin
                        cenw = 1'b0; aw = 10'd500; dw = 8'hA5;
                    end
                    if (sc == 4) begin
                        cenw = 1'b0; aw = 10'd10; dw = 8'h5A;
                    end
                    if (sc == 6) begin
                        stall = 0;
                        f2 = 1;
                    end
                end
            end
            if (mode == 3 && cnt >= 400) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_ovld", 32'(ovld), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_olast", 32'(olast), 32'd0);
                tick();
                tick();
                rst = 1'b0;
                guard = 99999;
            end
        end
        if (mode != 3) chk("stream_timeout", 32'(ndone == d0), 32'd0);
        rnd = 0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        cenw = 1'b1;
        aw = '0;
        dw = '0;
        go = 1'b0;
        ordy = 1'b0;
        for (int i = 0; i < D; i++) refmem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ovld", 32'(ovld), 32'd0);
        chk("reset_data", 32'(data_o), 32'd0);
        chk("reset_olast", 32'(olast), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < D; i++) begin
            tick();
            cenw = 1'b0;
            aw = 10'(i);
            dw = 8'(i);
        end
        tick();

        run_stream(0);
        chk("lit_w0", 32'(got[0]), 32'h00);
        chk("lit_w255", 32'(got[255]), 32'hFF);
        chk("lit_w783", 32'(got[783]), 32'h0F);
        chk("lit_ndone1", 32'(ndone), 32'd1);

        for (int i = 0; i < 60; i++) begin
            tick();
            cenw = 1'b0;
            aw = 10'($urandom_range(0, 1023));
            dw = 8'($urandom);
        end
        tick();
        cenw = 1'b0;
        aw = 10'd10;
        dw = 8'h3C;
        tick();

        run_stream(1);
        chk("lit_ndone2", 32'(ndone), 32'd2);

        run_stream(2);
        chk("lit_w500", 32'(got[500]), 32'hA5);
        chk("lit_w10_old", 32'(got[10]), 32'h3C);
        chk("lit_ndone3", 32'(ndone), 32'd3);

        run_stream(3);
        repeat (3) tick();
        chk("lit_ndone_rst", 32'(ndone), 32'd3);

        run_stream(0);
        chk("lit_w500_again", 32'(got[500]), 32'hA5);
        chk("lit_w10_new", 32'(got[10]), 32'h5A);
        chk("lit_ndone4", 32'(ndone), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
